div32_seq: RTL

Multi-cycle 32-bit integer divider for the ALU datapath. It produces quotient and remainder using a restoring shift-subtract loop, evaluating one compare-and-subtract (a less-than test of the partial remainder against the divisor) per clock. It is the iterative consumer of the compare/subtract primitive, sitting beside the combinational ALU ops behind a start/busy/done handshake. Signed and unsigned division are selected per operation.

---
 rtl/div32_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider: one compare-and-subtract per clock,
// signed/unsigned per operation, start/busy/done handshake.
module div32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] dvd_q;    // dividend magnitude shifts out MSB-first, quotient bits shift in
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dz_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] quo_q;
  logic [31:0] rmd_q;

  logic        a_neg;
  logic        b_neg;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_d;
  logic [31:0] dvd_d;

  always_comb begin
    a_neg   = is_signed & a[31];
    b_neg   = is_signed & b[31];
    shifted = {rem_q, dvd_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = diff[32] ? shifted[31:0] : diff[31:0];
    dvd_d   = {dvd_q[30:0], ~diff[32]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            dvd_q   <= a_neg ? -a : a;
            dvs_q   <= b_neg ? -b : b;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= (b == '0);
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= FIX;
        end
        FIX: begin
          // With a zero divisor every step subtracts nothing, so rem_q ends as |a|
          // and the sign fix-up restores the original dividend bits.
          quo_q   <= dz_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
          rmd_q   <= r_neg_q ? -rem_q : rem_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule
